// File: rtl/bcrypt_core_rx_pkg.sv
// Shared definitions for the bcrypt core receive path: bus control
// encodings, default frame lengths, error-bit positions and FSM/route types.
// These values were previously in bcrypt.vh.
package bcrypt_core_rx_pkg;

  // Bus control encodings
  localparam logic [1:0] CTRL_IDLE       = 2'b00;
  localparam logic [1:0] CTRL_INIT_START = 2'b01;
  localparam logic [1:0] CTRL_DATA_START = 2'b10;
  localparam logic [1:0] CTRL_END        = 2'b11;

  // Frame lengths (words)
  localparam int unsigned DEF_INIT_PN_WORDS = 30;
  localparam int unsigned DEF_S_WORDS       = 1024;
  localparam int unsigned DEF_DATA_WORDS    = 31;

  // Sticky error flag positions
  localparam int unsigned ERR_FRAME = 0;  // bad END placement / missing END
  localparam int unsigned ERR_START = 1;  // START seen mid-frame
  localparam int unsigned ERR_BUSY  = 2;  // DATA_START while PD still busy

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT_RX,
    ST_DATA_RX,
    ST_ERROR
  } rx_state_t;

  typedef enum logic [1:0] {
    DEST_PN,
    DEST_S,
    DEST_PD
  } wr_dest_t;

  function automatic logic is_start(input logic [1:0] c);
    return (c == CTRL_INIT_START) || (c == CTRL_DATA_START);
  endfunction

endpackage

// File: rtl/bcrypt_core_rx_if.sv
// Data-batch bus from the bcrypt data transmitter: one byte plus 2-bit
// control per cycle.
//   din  : data byte
//   ctrl : CTRL_INIT_START / CTRL_DATA_START / CTRL_END / CTRL_IDLE
interface bcrypt_core_rx_if;
  logic [7:0] din;
  logic [1:0] ctrl;

  modport master (output din, output ctrl);
  modport slave  (input  din, input  ctrl);
endinterface

// File: rtl/bcrypt_core_rx_byte_to_word.sv
// Byte-to-word deserializer. Collects four little-endian bytes (byte 0 in
// bits 7:0) and presents the assembled word with a registered 1-cycle valid.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : force byte counter back to 0
//   en_i          : din_i carries a byte this cycle
//   keep_i        : allow the strobe for a word completing this cycle
//   din_i         : data byte
//   byte_cnt_o    : index of the byte expected this cycle
//   word_o        : last completed word (registered)
//   word_valid_o  : 1-cycle strobe, one cycle after the 4th byte
module bcrypt_byte_to_word (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        keep_i,
  input  logic [7:0]  din_i,
  output logic [1:0]  byte_cnt_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  byte_cnt_q;
  logic [31:0] shift_q;
  logic [31:0] word_q;
  logic        valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clr_i) begin
        byte_cnt_q <= '0;
      end else if (en_i) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        // Bytes enter at the top and move down, so byte 0 ends in 7:0
        shift_q    <= {din_i, shift_q[31:8]};
        if (byte_cnt_q == 2'd3 && keep_i) begin
          word_q  <= {din_i, shift_q[31:8]};
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign byte_cnt_o   = byte_cnt_q;
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/bcrypt_core_rx.sv
// Receive end of the data-batch bus for one bcrypt core. Deserializes the
// byte stream into 32-bit words and steers init frames to PN then S memory,
// data frames to PD memory; reports completion and sticky protocol errors.
//   CLK, rst_n          : clock, async active-low reset
//   bus (slave)         : din[7:0], ctrl[1:0]
//   pd_busy             : core still reading PD; sampled at DATA_START only
//   pn_wr_en/pn_addr    : PN memory write port (0..29)
//   s_wr_en/s_addr      : S memory write port
//   pd_wr_en/pd_addr    : PD memory write port (0..30)
//   wr_data             : word shared by all write ports
//   init_done/data_done : 1-cycle pulse with the final write of a good frame
//   rx_busy             : frame in progress
//   error               : sticky flags, see ERR_* in the package
module bcrypt_core_rx
  import bcrypt_core_rx_pkg::*;
#(
  parameter int unsigned INIT_PN_WORDS = DEF_INIT_PN_WORDS,
  parameter int unsigned S_WORDS       = DEF_S_WORDS,
  parameter int unsigned DATA_WORDS    = DEF_DATA_WORDS
) (
  input  logic                CLK,
  input  logic                rst_n,
  bcrypt_core_rx_if.slave     bus,
  input  logic                pd_busy,
  output logic                pn_wr_en,
  output logic [4:0]          pn_addr,
  output logic                s_wr_en,
  output logic [9:0]          s_addr,
  output logic                pd_wr_en,
  output logic [4:0]          pd_addr,
  output logic [31:0]         wr_data,
  output logic                init_done,
  output logic                data_done,
  output logic                rx_busy,
  output logic [2:0]          error
);

  localparam logic [10:0] INIT_LAST = 11'(INIT_PN_WORDS + S_WORDS - 1);
  localparam logic [10:0] DATA_LAST = 11'(DATA_WORDS - 1);
  localparam logic [10:0] PN_SPAN   = 11'(INIT_PN_WORDS);

  rx_state_t   state_q;
  logic [10:0] word_cnt_q;
  wr_dest_t    dest_q;
  logic [4:0]  pn_addr_q;
  logic [9:0]  s_addr_q;
  logic [4:0]  pd_addr_q;
  logic        init_done_q;
  logic        data_done_q;
  logic        rx_busy_q;
  logic [2:0]  error_q;

  logic [1:0]  byte_cnt;
  logic [31:0] word_data;
  logic        word_valid;

  logic idle;
  logic in_frame;
  logic start_seen;
  logic end_seen;
  logic word_end;
  logic last_word;
  logic take_byte;
  logic frame_err;

  always_comb begin
    idle       = (state_q == ST_IDLE);
    in_frame   = (state_q == ST_INIT_RX) || (state_q == ST_DATA_RX);
    start_seen = is_start(bus.ctrl);
    end_seen   = (bus.ctrl == CTRL_END);
    word_end   = (byte_cnt == 2'd3);
    last_word  = (word_cnt_q == ((state_q == ST_INIT_RX) ? INIT_LAST : DATA_LAST));
    take_byte  = in_frame && !start_seen;
    // END must coincide exactly with byte 3 of the final word
    frame_err  = take_byte && (end_seen != (word_end && last_word));
  end

  // A word that completes in an erroring cycle is dropped via keep_i
  bcrypt_byte_to_word u_b2w (
    .clk_i        (CLK),
    .rst_ni       (rst_n),
    .clr_i        (idle),
    .en_i         (take_byte),
    .keep_i       (!frame_err),
    .din_i        (bus.din),
    .byte_cnt_o   (byte_cnt),
    .word_o       (word_data),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      dest_q      <= DEST_PN;
      pn_addr_q   <= '0;
      s_addr_q    <= '0;
      pd_addr_q   <= '0;
      init_done_q <= 1'b0;
      data_done_q <= 1'b0;
      rx_busy_q   <= 1'b0;
      error_q     <= '0;
    end else begin
      init_done_q <= 1'b0;
      data_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          word_cnt_q <= '0;
          case (bus.ctrl)
            CTRL_INIT_START: begin
              state_q   <= ST_INIT_RX;
              rx_busy_q <= 1'b1;
            end
            CTRL_DATA_START: begin
              if (pd_busy) begin
                error_q[ERR_BUSY] <= 1'b1;
                state_q           <= ST_ERROR;
              end else begin
                state_q   <= ST_DATA_RX;
                rx_busy_q <= 1'b1;
              end
            end
            CTRL_END: begin
              error_q[ERR_FRAME] <= 1'b1;
              state_q            <= ST_ERROR;
            end
            default: ;
          endcase
        end

        ST_INIT_RX, ST_DATA_RX: begin
          if (start_seen) begin
            error_q[ERR_START] <= 1'b1;
            state_q            <= ST_ERROR;
            rx_busy_q          <= 1'b0;
          end else if (frame_err) begin
            error_q[ERR_FRAME] <= 1'b1;
            state_q            <= ST_ERROR;
            rx_busy_q          <= 1'b0;
          end else if (word_end) begin
            word_cnt_q <= word_cnt_q + 11'd1;
            if (state_q == ST_DATA_RX) begin
              dest_q    <= DEST_PD;
              pd_addr_q <= word_cnt_q[4:0];
            end else if (word_cnt_q < PN_SPAN) begin
              dest_q    <= DEST_PN;
              pn_addr_q <= word_cnt_q[4:0];
            end else begin
              dest_q   <= DEST_S;
              s_addr_q <= 10'(word_cnt_q - PN_SPAN);
            end
            if (last_word) begin
              init_done_q <= (state_q == ST_INIT_RX);
              data_done_q <= (state_q == ST_DATA_RX);
              rx_busy_q   <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end

        ST_ERROR: ;

        default: state_q <= ST_ERROR;
      endcase
    end
  end

  assign pn_wr_en  = word_valid && (dest_q == DEST_PN);
  assign s_wr_en   = word_valid && (dest_q == DEST_S);
  assign pd_wr_en  = word_valid && (dest_q == DEST_PD);
  assign pn_addr   = pn_addr_q;
  assign s_addr    = s_addr_q;
  assign pd_addr   = pd_addr_q;
  assign wr_data   = word_data;
  assign init_done = init_done_q;
  assign data_done = data_done_q;
  assign rx_busy   = rx_busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_bcrypt_core_rx.sv
// Directed bench for bcrypt_core_rx: init/data frames, framing errors,
// pd_busy handling and reset mid-frame.
module tb_bcrypt_core_rx;
  import bcrypt_core_rx_pkg::*;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        pd_busy = 1'b0;
  logic        pn_wr_en, s_wr_en, pd_wr_en;
  logic [4:0]  pn_addr, pd_addr;
  logic [9:0]  s_addr;
  logic [31:0] wr_data;
  logic        init_done, data_done, rx_busy;
  logic [2:0]  error;

  bcrypt_core_rx_if bus_if ();

  bcrypt_core_rx #(
    .INIT_PN_WORDS (30),
    .S_WORDS       (1024),
    .DATA_WORDS    (31)
  ) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .pd_busy   (pd_busy),
    .pn_wr_en  (pn_wr_en),
    .pn_addr   (pn_addr),
    .s_wr_en   (s_wr_en),
    .s_addr    (s_addr),
    .pd_wr_en  (pd_wr_en),
    .pd_addr   (pd_addr),
    .wr_data   (wr_data),
    .init_done (init_done),
    .data_done (data_done),
    .rx_busy   (rx_busy),
    .error     (error)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word content model for both frame kinds
  function automatic logic [31:0] word_val(input bit init, input int w);
    if (init) begin
      if (w == 0) return 32'h243f6a88;
      return 32'hd1310ba6 + 32'(w) * 32'h00010001;
    end
    if (w < 18) return 32'h11111111 + 32'(w) * 32'h01010101;
    if (w == 18) return 32'h00000040;
    return 32'ha5000000 | 32'(w);
  endfunction

  // Write monitor, sampled on the falling edge
  logic        mon_clr = 1'b0;
  int          pn_cnt, s_cnt, pd_cnt, init_cnt, data_cnt, pn_last, s_last;
  int          seq_bad = 0;
  logic [31:0] pn0, pd18;

  always @(negedge CLK) begin
    if (mon_clr) begin
      pn_cnt = 0; s_cnt = 0; pd_cnt = 0; init_cnt = 0; data_cnt = 0;
      pn_last = -1; s_last = -1; pn0 = '0; pd18 = '0;
    end else begin
      if ($countones({pn_wr_en, s_wr_en, pd_wr_en}) > 1) seq_bad++;
      if (pn_wr_en) begin
        if (32'(pn_addr) != pn_cnt || wr_data != word_val(1'b1, pn_cnt)) seq_bad++;
        if (pn_addr == 5'd0) pn0 = wr_data;
        pn_last = int'(pn_addr);
        pn_cnt++;
      end
      if (s_wr_en) begin
        if (32'(s_addr) != s_cnt || wr_data != word_val(1'b1, 30 + s_cnt)) seq_bad++;
        s_last = int'(s_addr);
        s_cnt++;
      end
      if (pd_wr_en) begin
        if (32'(pd_addr) != pd_cnt || wr_data != word_val(1'b0, pd_cnt)) seq_bad++;
        if (pd_addr == 5'd18) pd18 = wr_data;
        pd_cnt++;
      end
      if (init_done) init_cnt++;
      if (data_done) data_cnt++;
    end
  end

  task automatic cyc(input logic [1:0] c, input logic [7:0] d);
    bus_if.ctrl = c;
    bus_if.din  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(CTRL_IDLE, 8'h00);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge CLK);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    bus_if.ctrl = CTRL_IDLE;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  // Sends START, then words; at (cut_w, cut_b) drives cut_c with that byte
  // and stops. busy_w raises pd_busy at the start of that word.
  task automatic send_frame(input logic [1:0] st, input bit init, input int nw,
                            input int cut_w, input int cut_b, input logic [1:0] cut_c,
                            input int busy_w);
    logic [31:0] v;
    cyc(st, 8'h00);
    for (int w = 0; w < nw; w++) begin
      v = word_val(init, w);
      if (w == busy_w) pd_busy = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (w == cut_w && b == cut_b) begin
          cyc(cut_c, v[8*b +: 8]);
          return;
        end
        cyc(CTRL_IDLE, v[8*b +: 8]);
      end
    end
  endtask

  initial begin
    bus_if.ctrl = CTRL_IDLE;
    bus_if.din  = 8'h00;
    clear_mon();
    @(posedge CLK);
    #1;
    chk("rst_strobes", {29'b0, pn_wr_en, s_wr_en, pd_wr_en}, 32'h0);
    chk("rst_done", {30'b0, init_done, data_done}, 32'h0);
    chk("rst_busy", {31'b0, rx_busy}, 32'h0);
    chk("rst_err", {29'b0, error}, 32'h0);
    chk("rst_data", wr_data, 32'h0);
    chk("rst_addr", {12'b0, pn_addr, s_addr, pd_addr}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Full init frame
    clear_mon();
    send_frame(CTRL_INIT_START, 1'b1, 1054, 1053, 3, CTRL_END, -1);
    chk("init_done_pulse", {31'b0, init_done}, 32'h1);
    chk("init_last_wr", {31'b0, s_wr_en}, 32'h1);
    chk("init_last_addr", {22'b0, s_addr}, 32'd1023);
    chk("init_busy_drop", {31'b0, rx_busy}, 32'h0);
    idle(3);
    chk("init_pn_cnt", pn_cnt, 30);
    chk("init_pn_last", pn_last, 29);
    chk("init_pn0", pn0, 32'h243f6a88);
    chk("init_s_cnt", s_cnt, 1024);
    chk("init_done_cnt", init_cnt, 1);
    chk("init_err", {29'b0, error}, 32'h0);
    chk("init_seq", seq_bad, 0);

    // Full data frame
    clear_mon();
    send_frame(CTRL_DATA_START, 1'b0, 31, 30, 3, CTRL_END, -1);
    chk("data_done_pulse", {31'b0, data_done}, 32'h1);
    chk("data_last_wr", {31'b0, pd_wr_en}, 32'h1);
    chk("data_last_addr", {27'b0, pd_addr}, 32'd30);
    idle(3);
    chk("data_pd_cnt", pd_cnt, 31);
    chk("data_pd18", pd18, 32'h00000040);
    chk("data_done_cnt", data_cnt, 1);
    chk("data_err", {29'b0, error}, 32'h0);

    // pd_busy rising mid-frame is harmless
    clear_mon();
    send_frame(CTRL_DATA_START, 1'b0, 31, 30, 3, CTRL_END, 10);
    pd_busy = 1'b0;
    idle(3);
    chk("busymid_pd_cnt", pd_cnt, 31);
    chk("busymid_done", data_cnt, 1);
    chk("busymid_err", {29'b0, error}, 32'h0);

    // END on byte 2 of the final data word
    clear_mon();
    send_frame(CTRL_DATA_START, 1'b0, 31, 30, 2, CTRL_END, -1);
    idle(3);
    chk("endearly_err", {29'b0, error}, 32'h1);
    chk("endearly_done", data_cnt, 0);
    chk("endearly_pd_cnt", pd_cnt, 30);
    chk("endearly_busy", {31'b0, rx_busy}, 32'h0);
    clear_mon();
    send_frame(CTRL_INIT_START, 1'b1, 8, -1, 0, CTRL_IDLE, -1);
    idle(3);
    chk("errhold_pn_cnt", pn_cnt, 0);
    chk("errhold_err", {29'b0, error}, 32'h1);
    chk("errhold_busy", {31'b0, rx_busy}, 32'h0);
    do_reset();
    chk("reset_clears_err", {29'b0, error}, 32'h0);

    // END while idle
    cyc(CTRL_END, 8'h00);
    idle(2);
    chk("idle_end_err", {29'b0, error}, 32'h1);
    do_reset();

    // Byte 3 of final word without END
    clear_mon();
    send_frame(CTRL_DATA_START, 1'b0, 31, 30, 3, CTRL_IDLE, -1);
    idle(3);
    chk("noend_err", {29'b0, error}, 32'h1);
    chk("noend_pd_cnt", pd_cnt, 30);
    chk("noend_done", data_cnt, 0);
    do_reset();

    // DATA_START while PD busy
    clear_mon();
    pd_busy = 1'b1;
    send_frame(CTRL_DATA_START, 1'b0, 31, 30, 3, CTRL_END, -1);
    pd_busy = 1'b0;
    idle(3);
    chk("pdbusy_err", {29'b0, error}, 32'h4);
    chk("pdbusy_pd_cnt", pd_cnt, 0);
    chk("pdbusy_done", data_cnt, 0);
    do_reset();

    // INIT_START at word 500 of an init frame
    clear_mon();
    send_frame(CTRL_INIT_START, 1'b1, 1054, 500, 0, CTRL_INIT_START, -1);
    idle(3);
    chk("restart_err", {29'b0, error}, 32'h2);
    chk("restart_pn_cnt", pn_cnt, 30);
    chk("restart_s_cnt", s_cnt, 470);
    chk("restart_s_last", s_last, 469);
    chk("restart_done", init_cnt, 0);
    do_reset();

    // Reset mid data frame, then a fresh frame
    clear_mon();
    send_frame(CTRL_DATA_START, 1'b0, 31, 10, 2, CTRL_IDLE, -1);
    chk("midrst_busy_before", {31'b0, rx_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_async", {30'b0, rx_busy, pd_wr_en}, 32'h0);
    clear_mon();
    idle(2);
    rst_n = 1'b1;
    idle(4);
    chk("midrst_no_stale", pd_cnt, 0);
    send_frame(CTRL_DATA_START, 1'b0, 31, 30, 3, CTRL_END, -1);
    idle(3);
    chk("midrst_pd_cnt", pd_cnt, 31);
    chk("midrst_done", data_cnt, 1);
    chk("midrst_err", {29'b0, error}, 32'h0);
    chk("final_seq", seq_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
